// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_pkg
// Purpose  : Shared state encoding and sizing helpers for multdiv_unit.
// Revision : 1.0
// ============================================================================
package multdiv_pkg;

  localparam int c_DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

  localparam int c_DEF_CNT_W = cnt_width(c_DEF_WIDTH);

endpackage
`default_nettype wire

// File: rtl/multdiv_counter.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_counter
// Purpose  : Iteration counter with synchronous clear, enable and a flag on
//            the last iteration.
// Revision : 1.0
// ============================================================================
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int CNT_W = c_DEF_CNT_W,
  parameter int LIMIT = c_DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_count;

  // Wraps to zero after the last iteration so an idle counter always rests at 0.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_tc ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_unit
// Purpose  : Fixed-latency signed multiply (shift-add) / divide (restoring).
// Revision : 1.0
// ============================================================================
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int c_CNT_W = cnt_width(ITERS);

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  state_t               r_state, w_next_state;
  logic [WIDTH-1:0]     r_opa, r_opb;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_result;
  logic                 r_exc;

  logic                 w_start, w_busy, w_tc;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic                 w_sign_neg;
  logic [WIDTH:0]       w_mul_sum, w_mul_hi;
  logic [2*WIDTH-1:0]   w_mul_next, w_prod;
  logic                 w_mul_exc;
  logic [WIDTH:0]       w_div_sh;
  logic [WIDTH-1:0]     w_div_diff, w_div_rem, w_q;
  logic                 w_div_ge, w_div_zero, w_div_ovf;
  logic [2*WIDTH-1:0]   w_div_next, w_step;
  logic [WIDTH-1:0]     w_final;
  logic                 w_final_exc;

  assign w_start    = ctrl_MULT | ctrl_DIV;
  assign w_busy     = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_mag_a    = f_abs(r_opa);
  assign w_mag_b    = f_abs(r_opb);
  assign w_sign_neg = r_opa[WIDTH-1] ^ r_opb[WIDTH-1];

  // Multiply: r_acc = {partial sum, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mag_a};
  assign w_mul_hi   = r_acc[0] ? w_mul_sum : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_mul_next = {w_mul_hi, r_acc[WIDTH-1:1]};
  assign w_prod     = w_sign_neg ? -w_mul_next : w_mul_next;
  assign w_mul_exc  = (w_prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){w_prod[WIDTH-1]}});

  // Divide: r_acc = {remainder, dividend bits becoming quotient bits}.
  assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, w_mag_b});
  assign w_div_diff = WIDTH'(w_div_sh - {1'b0, w_mag_b});
  assign w_div_rem  = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
  assign w_q        = w_sign_neg ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
  assign w_div_zero = (r_opb == '0);
  assign w_div_ovf  = (r_opa == {1'b1, {(WIDTH-1){1'b0}}}) && (r_opb == '1);

  assign w_step = (r_state == ST_MUL) ? w_mul_next : w_div_next;

  always_comb begin
    w_final     = '0;
    w_final_exc = 1'b0;
    if (r_state == ST_MUL) begin
      w_final     = w_prod[WIDTH-1:0];
      w_final_exc = w_mul_exc;
    end else if (w_div_zero) begin
      w_final_exc = 1'b1;
    end else begin
      w_final     = w_q;
      w_final_exc = w_div_ovf;
    end
  end

  multdiv_counter #(
    .CNT_W (c_CNT_W),
    .LIMIT (ITERS)
  ) u_counter (
    .clk      (clock),
    .rst      (reset),
    .i_clear  (w_start),
    .i_enable (w_busy),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A start in any state restarts; multiply takes priority over divide.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_MUL,
      ST_DIV:  if (w_tc) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = r_state;
    endcase
    if (w_start) begin
      w_next_state = ctrl_MULT ? ST_MUL : ST_DIV;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_opa <= data_operandA;
      r_opb <= data_operandB;
      r_acc <= {{WIDTH{1'b0}}, ctrl_MULT ? f_abs(data_operandB) : f_abs(data_operandA)};
    end else if (w_busy) begin
      r_acc <= w_step;
      if (w_tc) begin
        r_result <= w_final;
        r_exc    <= w_final_exc;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == ST_DONE);
  assign busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_unit
// Purpose  : Self-checking bench for multdiv_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] last_res = 32'h0;
  logic        last_exc = 1'b0;

  always #5 clock = ~clock;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  function automatic void model_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'h0) begin
      r = 32'h0; e = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000; e = 1'b1;
    end else begin
      r = sa / sb; e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 200)) - 32'd100;
      2:       return sp[$urandom_range(0, 4)];
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  // Start edge is the posedge between the two negedges below.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called at the negedge right after the start edge; lat counts edges after it.
  task automatic wait_done(output logic [31:0] res, output logic exc, output int lat,
                           output bit busy_ok, output bit single);
    lat     = -1;
    res     = 'x;
    exc     = 1'bx;
    busy_ok = (busy === 1'b1);
    single  = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        lat = n;
        res = data_result;
        exc = data_exception;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    @(negedge clock);
    single = (data_resultRDY === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    checks++; if (data_result !== 32'h0) $display("FAIL reset_result got %h want 0", data_result); else passed++;
    checks++; if (data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", data_exception); else passed++;
    checks++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b want 0", data_resultRDY); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_mul_directed();
    logic [31:0] ta [3] = '{32'd7, 32'h00010000, 32'h7FFFFFFF};
    logic [31:0] tb [3] = '{32'hFFFFFFFD, 32'h00010000, 32'd1};
    logic [31:0] tr [3] = '{32'hFFFFFFEB, 32'h00000000, 32'h7FFFFFFF};
    logic        te [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] res; logic exc; int lat; bit bok, single;
    for (int i = 0; i < 3; i++) begin
      start_op(1'b1, 1'b0, ta[i], tb[i]);
      wait_done(res, exc, lat, bok, single);
      checks++; if (lat != 32) $display("FAIL mul_dir_lat[%0d] got %0d want 32", i, lat); else passed++;
      checks++; if (!bok) $display("FAIL mul_dir_busy[%0d] got bad busy want 1 until done", i); else passed++;
      checks++; if (!single) $display("FAIL mul_dir_pulse[%0d] got rdy/busy after done want 0", i); else passed++;
      checks++; if (res !== tr[i]) $display("FAIL mul_dir_res[%0d] got %h want %h", i, res, tr[i]); else passed++;
      checks++; if (exc !== te[i]) $display("FAIL mul_dir_exc[%0d] got %b want %b", i, exc, te[i]); else passed++;
      last_res = tr[i]; last_exc = te[i];
    end
  endtask

  task automatic test_mul_random();
    logic [31:0] a, b, er, res; logic ee, exc; int lat; bit bok, single;
    for (int i = 0; i < 10; i++) begin
      a = rnd_op(); b = rnd_op();
      model_mul(a, b, er, ee);
      start_op(1'b1, 1'b0, a, b);
      wait_done(res, exc, lat, bok, single);
      checks++; if (lat != 32) $display("FAIL mul_rnd_lat[%0d] got %0d want 32", i, lat); else passed++;
      checks++; if (res !== er) $display("FAIL mul_rnd_res[%0d] %h*%h got %h want %h", i, a, b, res, er); else passed++;
      checks++; if (exc !== ee) $display("FAIL mul_rnd_exc[%0d] %h*%h got %b want %b", i, a, b, exc, ee); else passed++;
      last_res = er; last_exc = ee;
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] ta [5] = '{32'hFFFFFFF9, 32'd5, 32'h80000000, 32'd0, 32'd100};
    logic [31:0] tb [5] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd9, 32'd7};
    logic [31:0] tr [5] = '{32'hFFFFFFFD, 32'h0, 32'h80000000, 32'h0, 32'd14};
    logic        te [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] res; logic exc; int lat; bit bok, single;
    for (int i = 0; i < 5; i++) begin
      start_op(1'b0, 1'b1, ta[i], tb[i]);
      wait_done(res, exc, lat, bok, single);
      checks++; if (lat != 32) $display("FAIL div_dir_lat[%0d] got %0d want 32", i, lat); else passed++;
      checks++; if (!bok || !single) $display("FAIL div_dir_handshake[%0d] got busy_ok=%0b single=%0b want 1", i, bok, single); else passed++;
      checks++; if (res !== tr[i]) $display("FAIL div_dir_res[%0d] got %h want %h", i, res, tr[i]); else passed++;
      checks++; if (exc !== te[i]) $display("FAIL div_dir_exc[%0d] got %b want %b", i, exc, te[i]); else passed++;
      last_res = tr[i]; last_exc = te[i];
    end
  endtask

  task automatic test_div_random();
    logic [31:0] a, b, er, res; logic ee, exc; int lat; bit bok, single;
    for (int i = 0; i < 10; i++) begin
      a = rnd_op();
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : rnd_op();
      model_div(a, b, er, ee);
      start_op(1'b0, 1'b1, a, b);
      wait_done(res, exc, lat, bok, single);
      checks++; if (lat != 32) $display("FAIL div_rnd_lat[%0d] got %0d want 32", i, lat); else passed++;
      checks++; if (res !== er) $display("FAIL div_rnd_res[%0d] %h/%h got %h want %h", i, a, b, res, er); else passed++;
      checks++; if (exc !== ee) $display("FAIL div_rnd_exc[%0d] %h/%h got %b want %b", i, a, b, exc, ee); else passed++;
      last_res = er; last_exc = ee;
    end
  endtask

  task automatic test_hold();
    int bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (data_result !== last_res || data_exception !== last_exc || data_resultRDY !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL hold got %0d bad cycles want 0 (result %h want %h)", bad, data_result, last_res); else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] res; logic exc; int lat; bit bok, single;
    int rdy_seen = 0;
    int bad_hold = 0;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_seen++;
      if (data_result !== last_res) bad_hold++;
    end
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    checks++; if (data_result !== last_res) $display("FAIL abort_hold_now got %h want %h", data_result, last_res); else passed++;
    wait_done(res, exc, lat, bok, single);
    checks++; if (rdy_seen != 0) $display("FAIL abort_early_rdy got %0d want 0", rdy_seen); else passed++;
    checks++; if (bad_hold != 0) $display("FAIL abort_hold got %0d changes want 0", bad_hold); else passed++;
    checks++; if (lat != 32) $display("FAIL abort_lat got %0d want 32", lat); else passed++;
    checks++; if (!single) $display("FAIL abort_pulse got extra rdy want single pulse"); else passed++;
    checks++; if (res !== 32'd14) $display("FAIL abort_res got %h want %h", res, 32'd14); else passed++;
    checks++; if (exc !== 1'b0) $display("FAIL abort_exc got %b want 0", exc); else passed++;
    last_res = 32'd14; last_exc = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] res; logic exc; int lat; bit bok, single;
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_done(res, exc, lat, bok, single);
    checks++; if (lat != 32) $display("FAIL both_lat got %0d want 32", lat); else passed++;
    checks++; if (res !== 32'd18) $display("FAIL both_res got %h want %h", res, 32'd18); else passed++;
    checks++; if (exc !== 1'b0) $display("FAIL both_exc got %b want 0", exc); else passed++;
    last_res = 32'd18; last_exc = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] res; logic exc; int lat; bit bok, single;
    int rdy_seen = 0;
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (19) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (data_result !== 32'h0) $display("FAIL rst_abort_result got %h want 0", data_result); else passed++;
    checks++; if (data_exception !== 1'b0) $display("FAIL rst_abort_exc got %b want 0", data_exception); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_abort_busy got %b want 0", busy); else passed++;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    checks++; if (rdy_seen != 0) $display("FAIL rst_abort_rdy got %0d pulses want 0", rdy_seen); else passed++;
    start_op(1'b1, 1'b0, 32'd2, 32'd2);
    wait_done(res, exc, lat, bok, single);
    checks++; if (lat != 32) $display("FAIL rst_abort_next_lat got %0d want 32", lat); else passed++;
    checks++; if (res !== 32'd4) $display("FAIL rst_abort_next_res got %h want %h", res, 32'd4); else passed++;
    last_res = 32'd4; last_exc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    test_reset();
    test_mul_directed();
    test_hold();
    test_mul_random();
    test_div_directed();
    test_div_random();
    test_abort();
    test_simultaneous();
    test_hold();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
